// File: rtl/frame_buffer_manager.sv
// ----------------------------------------------------------------------------
// frame_buffer_manager
// N-way (2..8) frame buffer index manager between the AXI4 frame writer and
// the AXI4 frame reader / video timing generator. Tracks which buffer is
// being written, which is displayed and which completed frame is waiting for
// the next display vsync. Reports swaps, drops and repeats and keeps
// wrap-around statistics counters.
//
// Ports
//   clk_100Mhz          sole clock (AXI domain)
//   rst                 synchronous, active-high reset
//   writer_done         1-cycle pulse: writer finished a frame
//   vsync_sync2         synchronised vsync level; rising edge = display frame
//   w_frame_base_addr   writer base address
//   r_frame_base_addr   reader base address
//   w_buf_idx/r_buf_idx current writer / reader buffer index
//   wr_stall            completed frame waiting and no free buffer (2 bufs)
//   swap_pulse          reader moved to a new frame
//   drop_pulse          a completed, never-displayed frame was discarded
//   repeat_pulse        vsync edge with no new frame
//   frame_cnt/drop_cnt/repeat_cnt  wrap-around event counters
// ----------------------------------------------------------------------------
module frame_buffer_manager #(
   parameter int unsigned         NUM_BUFS   = 3,
   parameter int unsigned         ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]   BASE_ADDR  = ADDR_W'(32'h0100_0000),
   parameter logic [ADDR_W-1:0]   BUF_STRIDE = ADDR_W'(32'h0010_0000),
   parameter int unsigned         CNT_W      = 16
) (
   input  logic              clk_100Mhz,
   input  logic              rst,
   input  logic              writer_done,
   input  logic              vsync_sync2,
   output logic [ADDR_W-1:0] w_frame_base_addr,
   output logic [ADDR_W-1:0] r_frame_base_addr,
   output logic [2:0]        w_buf_idx,
   output logic [2:0]        r_buf_idx,
   output logic              wr_stall,
   output logic              swap_pulse,
   output logic              drop_pulse,
   output logic              repeat_pulse,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  repeat_cnt
);

   localparam int unsigned      IDX_W    = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFS - 1);

   // Buffer base address; the product is truncated to ADDR_W.
   function automatic logic [ADDR_W-1:0] buf_addr(input logic [IDX_W-1:0] idx);
      return BASE_ADDR + ADDR_W'(idx) * BUF_STRIDE;
   endfunction

   // State
   logic [IDX_W-1:0] w_idx, r_idx, rdy_idx;
   logic             rdy_valid;
   logic             vs_prev;

   // Next-state / event terms
   logic             vs_edge;
   logic             drop_c, swap_c, repeat_c;
   logic [IDX_W-1:0] rdy_idx_mid;
   logic             rdy_valid_mid;
   logic [IDX_W-1:0] r_idx_nxt, w_idx_nxt, rdy_idx_nxt;
   logic             rdy_valid_nxt;
   logic             wr_stall_nxt;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] cand;

   assign w_buf_idx = w_idx;
   assign r_buf_idx = r_idx;

   // Next-state: writer_done is applied first, then the vsync edge sees the
   // updated ready slot, so a frame finished on the vsync cycle is shown now.
   always_comb begin
      vs_edge       = vsync_sync2 & ~vs_prev;
      drop_c        = writer_done & rdy_valid;
      rdy_idx_mid   = writer_done ? w_idx : rdy_idx;
      rdy_valid_mid = writer_done | rdy_valid;
      swap_c        = vs_edge & rdy_valid_mid;
      repeat_c      = vs_edge & ~rdy_valid_mid;
      r_idx_nxt     = swap_c ? rdy_idx_mid : r_idx;
      rdy_idx_nxt   = rdy_idx_mid;
      rdy_valid_nxt = rdy_valid_mid & ~swap_c;
      w_idx_nxt     = w_idx;
      wr_stall_nxt  = wr_stall;
      free_idx      = w_idx;
      cand          = '0;

      // Round-robin free-buffer search from w_idx+1; iterating downwards
      // leaves the nearest qualifying candidate in free_idx.
      for (int k = int'(NUM_BUFS); k >= 1; k--) begin
         cand = IDX_W'((int'(w_idx) + k) % int'(NUM_BUFS));
         if (cand != r_idx_nxt && cand != rdy_idx_nxt)
            free_idx = cand;
      end

      if (NUM_BUFS > 2) begin
         if (writer_done)
            w_idx_nxt = free_idx;
      end else begin
         // Two buffers: no spare, writer stalls until the reader hands back
         // its old buffer on the next swap.
         if (writer_done)
            wr_stall_nxt = 1'b1;
         if (swap_c) begin
            w_idx_nxt    = r_idx;
            wr_stall_nxt = 1'b0;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         w_idx             <= '0;
         r_idx             <= LAST_IDX;
         rdy_idx           <= '0;
         rdy_valid         <= 1'b0;
         vs_prev           <= 1'b1;
         wr_stall          <= 1'b0;
         swap_pulse        <= 1'b0;
         drop_pulse        <= 1'b0;
         repeat_pulse      <= 1'b0;
         frame_cnt         <= '0;
         drop_cnt          <= '0;
         repeat_cnt        <= '0;
         w_frame_base_addr <= buf_addr('0);
         r_frame_base_addr <= buf_addr(LAST_IDX);
      end else begin
         w_idx             <= w_idx_nxt;
         r_idx             <= r_idx_nxt;
         rdy_idx           <= rdy_idx_nxt;
         rdy_valid         <= rdy_valid_nxt;
         vs_prev           <= vsync_sync2;
         wr_stall          <= wr_stall_nxt;
         swap_pulse        <= swap_c;
         drop_pulse        <= drop_c;
         repeat_pulse      <= repeat_c;
         w_frame_base_addr <= buf_addr(w_idx_nxt);
         r_frame_base_addr <= buf_addr(r_idx_nxt);
         if (writer_done)
            frame_cnt <= frame_cnt + CNT_W'(1);
         if (drop_c)
            drop_cnt <= drop_cnt + CNT_W'(1);
         if (repeat_c)
            repeat_cnt <= repeat_cnt + CNT_W'(1);
      end
   end

   // Writer and reader never share a buffer.
   a_w_ne_r : assert property (@(posedge clk_100Mhz) disable iff (rst)
                               w_idx != r_idx);

   // With a spare buffer the pending frame is distinct from both.
   if (NUM_BUFS > 2) begin : g_rdy_chk
      a_rdy_distinct : assert property (@(posedge clk_100Mhz) disable iff (rst)
                                        rdy_valid |-> (rdy_idx != w_idx && rdy_idx != r_idx));
   end

endmodule

// File: doc/frame_buffer_manager.md
# frame_buffer_manager

N-way frame buffer index manager for the camera-to-HDMI path. It sits in the 100 MHz AXI domain between the AXI4 writer (frame completion) and the AXI4 reader / video timing generator (display vsync). It generalises the fixed two-buffer swap to 2..8 buffers. It adds a latest-frame triple-buffer mode, drop/repeat detection and statistics counters. Outputs drive the writer's and reader's FRAME_BASE_ADDR directly.

## Interface
- NUM_BUFS, 3: number of frame buffers, legal 2..8.
- ADDR_W, 32: address width.
- BASE_ADDR, 32'h0100_0000: address of buffer 0.
- BUF_STRIDE, 32'h0010_0000: byte distance between consecutive buffers.
- CNT_W, 16: width of statistics counters.

Clock and reset: one clock; reset is synchronous and active-high.

- clk_100Mhz  in  1  sole clock (AXI domain).
- rst  in  1  synchronous, active-high reset.
- writer_done  in  1  one-cycle pulse: the writer finished a full frame into w_frame_base_addr.
- vsync_sync2  in  1  level, already synchronised to clk_100Mhz; a rising edge marks a display frame boundary (high for ≥1 cycle).
- w_frame_base_addr  out  ADDR_W  base address for the writer.
- r_frame_base_addr  out  ADDR_W  base address for the reader.
- w_buf_idx, r_buf_idx  out  3  current indices (debug).
- wr_stall  out  1  high when a completed frame awaits display and no free buffer exists (NUM_BUFS=2 only).
- swap_pulse  out  1  one cycle: reader switched to a new frame.
- drop_pulse  out  1  one cycle: a completed, never-displayed frame was discarded.
- repeat_pulse  out  1  one cycle: vsync edge with no new frame; reader repeats.
- frame_cnt, drop_cnt, repeat_cnt  out  CNT_W  wrap-around counters of writer_done, drop_pulse, repeat_pulse.

## Operation
- State: w_idx, r_idx, rdy_idx, rdy_valid, vs_prev.
- Reset values: w_idx=0, r_idx=NUM_BUFS-1, rdy_valid=0, rdy_idx=0, vs_prev=1. All pulses and counters are 0. wr_stall=0.
- vs_prev resets to 1, so a vsync already high at reset release produces no edge.
- vs_edge = vsync_sync2 & ~vs_prev.
- Address: addr = BASE_ADDR + idx*BUF_STRIDE, truncated to ADDR_W.

On writer_done:
- rdy_idx ← w_idx and rdy_valid ← 1.
- If rdy_valid was already 1, the old ready buffer is discarded and drop_pulse fires.
- NUM_BUFS≥3: w_idx ← the first index, searching round-robin from (w_idx+1) mod NUM_BUFS, that is neither r_next nor rdy_next.
- NUM_BUFS=2: w_idx is unchanged and wr_stall ← 1. The writer overwrites the ready buffer if it keeps going; each further writer_done before vsync is a drop.

On vs_edge:
- If rdy_valid=1 (after the writer_done update of the same cycle): r_idx ← rdy_idx, rdy_valid ← 0, swap_pulse fires.
- NUM_BUFS=2: on a swap, w_idx ← old r_idx and wr_stall ← 0.
- If rdy_valid=0: repeat_pulse fires and the indices are held.

Simultaneous writer_done and vs_edge: writer_done is applied first. The just-finished frame is displayed immediately (r_idx ← old w_idx). drop_pulse fires only if a prior ready frame existed. The free-buffer search excludes the new r_idx.

Invariant, checked by assertion: w_idx ≠ r_idx always. When NUM_BUFS≥3, rdy_idx is distinct from both while rdy_valid=1.

## Timing
- All outputs are registered. Indices, addresses and flags update on the edge that samples the event, so they are visible 1 cycle later.
- Pulses are exactly 1 cycle wide.
- Counters increment in the same cycle the corresponding pulse is asserted.
- Edge detection needs vsync_sync2 low for ≥1 cycle between frames. A level held for many cycles yields one edge only.
- rst asserted mid-operation: all state returns to reset values on the next clock edge, and any in-flight pulse is suppressed.
- Counters at all-ones wrap to 0.

## Test plan
- NUM_BUFS=3, reset → w_frame_base_addr=0x0100_0000, r_frame_base_addr=0x0120_0000, all pulses 0.
- NUM_BUFS=3 from reset: writer_done → w_idx=1. A second writer_done with no vsync → drop_pulse, rdy_idx=1, w_idx=0, drop_cnt=1. Then vsync edge → r_idx=1 (0x0110_0000), swap_pulse.
- NUM_BUFS=2 from reset: writer_done → wr_stall=1, w_idx stays 0. Vsync edge → r=0x0100_0000, w=0x0110_0000, wr_stall=0. This matches legacy double-buffer behaviour.
- Vsync edge with no completed frame → repeat_pulse, indices unchanged, repeat_cnt+1. Vsync held high 4 cycles → exactly one event.
- NUM_BUFS=3: writer_done and vs_edge in the same cycle from reset → r_idx=0, w_idx=1, swap_pulse=1, drop_pulse=0.
- Reset asserted mid-frame with rdy_valid=1 and vsync high → indices return to reset values, and no swap occurs at reset release while vsync stays high.
